// File: rtl/core_lsu_pkg.sv
// Shared constants and types for the load/store unit: control-field layout,
// access-size codes, FSM state encoding and the byte-enable mask helper.
package core_lsu_pkg;

    localparam int LSU_CTRL_WIDTH = 4;
    localparam int LSU_STORE_BIT  = 3;
    localparam int LSU_UNS_BIT    = 2;

    localparam logic [1:0] LSU_B = 2'b00;
    localparam logic [1:0] LSU_H = 2'b01;
    localparam logic [1:0] LSU_W = 2'b10;
    localparam logic [1:0] LSU_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    // Byte-enable pattern for an access of the given size at lane 0.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            LSU_B:   mask = 8'h01;
            LSU_H:   mask = 8'h03;
            LSU_W:   mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Combinational lane logic for the LSU: store data/strobe placement and the
// misalignment test on the incoming request, plus load extraction/extension
// on the returning doubleword.
module core_lsu_align
    import core_lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    // request side (execute-stage inputs)
    input  logic [1:0]      req_size_i,
    input  logic [2:0]      req_off_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic [XLEN-1:0] st_wdata_o,
    output logic [7:0]      st_wstrb_o,
    output logic            misalign_o,
    // load side (registered access info plus memory read data)
    input  logic [1:0]      ld_size_i,
    input  logic            ld_uns_i,
    input  logic [2:0]      ld_off_i,
    input  logic [XLEN-1:0] ld_rdata_i,
    output logic [XLEN-1:0] ld_data_o
);

    logic [XLEN-1:0] ld_shifted;

    // Store lanes: move data and strobe up to the addressed byte offset.
    always_comb begin
        st_wdata_o = req_wdata_i << {req_off_i, 3'b000};
        st_wstrb_o = size_mask(req_size_i) << req_off_i;
    end

    // Natural alignment test; byte accesses can never be misaligned.
    always_comb begin
        case (req_size_i)
            LSU_H:   misalign_o = req_off_i[0];
            LSU_W:   misalign_o = |req_off_i[1:0];
            LSU_D:   misalign_o = |req_off_i;
            default: misalign_o = 1'b0;
        endcase
    end

    // Load extraction: right-align the addressed lanes, then extend.
    // Doubleword loads ignore the unsigned bit.
    always_comb begin
        ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
        case (ld_size_i)
            LSU_B:   ld_data_o = {{(XLEN-8){ld_shifted[7] & ~ld_uns_i}}, ld_shifted[7:0]};
            LSU_H:   ld_data_o = {{(XLEN-16){ld_shifted[15] & ~ld_uns_i}}, ld_shifted[15:0]};
            LSU_W:   ld_data_o = {{(XLEN-32){ld_shifted[31] & ~ld_uns_i}}, ld_shifted[31:0]};
            default: ld_data_o = ld_shifted;
        endcase
    end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit for the memory stage. Runs one aligned access at a time on
// a 64-bit request/grant/response memory port; misaligned accesses complete
// immediately with a flag and never reach memory.
module core_lsu
    import core_lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [LSU_CTRL_WIDTH-1:0] lsu_ctrl_i,
    input  logic [XLEN-1:0]           addr_i,
    input  logic [XLEN-1:0]           wdata_i,
    output logic                      resp_valid_o,
    output logic [XLEN-1:0]           rdata_o,
    output logic                      misalign_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [XLEN-1:0]           mem_addr_o,
    output logic [XLEN-1:0]           mem_wdata_o,
    output logic [7:0]                mem_wstrb_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [XLEN-1:0]           mem_rdata_i
);

    lsu_state_e      state_q, state_d;
    logic [1:0]      ld_size_q, ld_size_d;
    logic            ld_uns_q, ld_uns_d;
    logic [2:0]      off_q, off_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            misalign_q, misalign_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]      mem_wstrb_q, mem_wstrb_d;

    logic [XLEN-1:0] st_wdata;
    logic [7:0]      st_wstrb;
    logic            req_misalign;
    logic [XLEN-1:0] ld_data;
    logic            req_is_store;

    assign req_is_store = lsu_ctrl_i[LSU_STORE_BIT];

    core_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .req_size_i  (lsu_ctrl_i[1:0]),
        .req_off_i   (addr_i[2:0]),
        .req_wdata_i (wdata_i),
        .st_wdata_o  (st_wdata),
        .st_wstrb_o  (st_wstrb),
        .misalign_o  (req_misalign),
        .ld_size_i   (ld_size_q),
        .ld_uns_i    (ld_uns_q),
        .ld_off_i    (off_q),
        .ld_rdata_i  (mem_rdata_i),
        .ld_data_o   (ld_data)
    );

    // Next-state and next-register values for the access FSM.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
        state_d     = state_q;
        ld_size_d   = ld_size_q;
        ld_uns_d    = ld_uns_q;
        off_d       = off_q;
        rdata_d     = rdata_q;
        misalign_d  = misalign_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    ld_size_d  = lsu_ctrl_i[1:0];
                    ld_uns_d   = lsu_ctrl_i[LSU_UNS_BIT];
                    off_d      = addr_i[2:0];
                    rdata_d    = '0;
                    misalign_d = req_misalign;
                    if (req_misalign) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d     = ST_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_is_store;
                        mem_addr_d  = {addr_i[XLEN-1:3], 3'b000};
                        mem_wdata_d = req_is_store ? st_wdata : '0;
                        mem_wstrb_d = req_is_store ? st_wstrb : 8'h00;
                    end
                end
            end
            ST_REQ: begin
                // Read data arriving before the grant is not ours; ignore it.
                if (mem_gnt_i) begin
                    mem_req_d = 1'b0;
                    state_d   = mem_we_q ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    rdata_d = ld_data;
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ld_size_q   <= LSU_B;
            ld_uns_q    <= 1'b0;
            off_q       <= 3'd0;
            rdata_q     <= '0;
            misalign_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            ld_size_q   <= ld_size_d;
            ld_uns_q    <= ld_uns_d;
            off_q       <= off_d;
            rdata_q     <= rdata_d;
            misalign_q  <= misalign_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    // Handshake outputs decode from state only; data outputs are registers.
    always_comb begin
        req_ready_o  = (state_q == ST_IDLE);
        resp_valid_o = (state_q == ST_RESP);
        rdata_o      = rdata_q;
        misalign_o   = misalign_q;
        mem_req_o    = mem_req_q;
        mem_we_o     = mem_we_q;
        mem_addr_o   = mem_addr_q;
        mem_wdata_o  = mem_wdata_q;
        mem_wstrb_o  = mem_wstrb_q;
    end

endmodule

// File: tb/tb_core_lsu.sv
// Directed testbench for core_lsu: hand-computed vectors for loads, stores,
// misaligned accesses, grant/rvalid stalls and reset in mid-access.
module tb_core_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  lsu_ctrl_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic        resp_valid_o;
    logic [63:0] rdata_o;
    logic        misalign_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_wstrb_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [63:0] mem_rdata_i;

    int n_checks = 0;
    int n_errors = 0;

    // Results captured by the access task.
    int          lat;
    int          req_cycles;
    logic        saw_req;
    logic        unstable;
    logic [63:0] cap_addr;
    logic [63:0] cap_wdata;
    logic [7:0]  cap_wstrb;
    logic        cap_we;
    logic [63:0] cap_rd;
    logic        cap_mis;
    logic        saw_resp;

    core_lsu #(
        .XLEN (64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .lsu_ctrl_i   (lsu_ctrl_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .resp_valid_o (resp_valid_o),
        .rdata_o      (rdata_o),
        .misalign_o   (misalign_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wstrb_o  (mem_wstrb_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and act as memory: grant after gnt_wait
    // refused REQ cycles (offering junk rvalid meanwhile), return mrdata after
    // rv_wait idle WAIT cycles. Leaves the LSU back in IDLE.
    task automatic access(input logic [3:0] ctrl, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] mrdata,
                          input int gnt_wait, input int rv_wait);
        int gcnt;
        int rcnt;
        bit in_wait;
        check("ready_before_req", {63'd0, req_ready_o}, 64'd1);
        req_valid_i = 1'b1;
        lsu_ctrl_i  = ctrl;
        addr_i      = addr;
        wdata_i     = wdata;
        cyc();
        req_valid_i = 1'b0;
        lsu_ctrl_i  = '0;
        addr_i      = '0;
        wdata_i     = '0;
        lat = 0; req_cycles = 0; saw_req = 1'b0; unstable = 1'b0;
        cap_addr = '0; cap_wdata = '0; cap_wstrb = '0; cap_we = 1'b0;
        gcnt = 0; rcnt = 0; in_wait = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
            if (resp_valid_o) begin
                lat = n;
                break;
            end
            if (mem_req_o) begin
                req_cycles++;
                if (!saw_req) begin
                    saw_req   = 1'b1;
                    cap_addr  = mem_addr_o;
                    cap_wdata = mem_wdata_o;
                    cap_wstrb = mem_wstrb_o;
                    cap_we    = mem_we_o;
                end else if (mem_addr_o !== cap_addr || mem_wdata_o !== cap_wdata ||
                             mem_wstrb_o !== cap_wstrb || mem_we_o !== cap_we) begin
                    unstable = 1'b1;
                end
                if (gcnt == gnt_wait) begin
                    mem_gnt_i = 1'b1;
                    in_wait   = 1'b1;
                end else begin
                    gcnt++;
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = 64'hDEAD_BEEF_DEAD_BEEF;
                end
            end else if (in_wait) begin
                if (rcnt == rv_wait) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = mrdata;
                end else begin
                    rcnt++;
                end
            end
            cyc();
        end
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        cap_rd  = rdata_o;
        cap_mis = misalign_o;
        cyc();
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid_i  = 1'b0;
        lsu_ctrl_i   = '0;
        addr_i       = '0;
        wdata_i      = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        saw_resp     = 1'b0;
        cyc();
        cyc();

        // Reset state
        check("rst_ready",    {63'd0, req_ready_o},  64'd1);
        check("rst_resp",     {63'd0, resp_valid_o}, 64'd0);
        check("rst_misalign", {63'd0, misalign_o},   64'd0);
        check("rst_mem_req",  {63'd0, mem_req_o},    64'd0);
        check("rst_mem_we",   {63'd0, mem_we_o},     64'd0);
        check("rst_rdata",    rdata_o,               64'd0);
        check("rst_mem_addr", mem_addr_o,            64'd0);
        check("rst_mem_wdata", mem_wdata_o,          64'd0);
        check("rst_mem_wstrb", {56'd0, mem_wstrb_o}, 64'd0);
        rst_n = 1'b1;
        cyc();

        // LB at 0x1003: byte 3 = 0x80, sign-extended
        access(4'b0000, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0);
        check("lb_lat",   lat,                  64'd3);
        check("lb_addr",  cap_addr,             64'h1000);
        check("lb_we",    {63'd0, cap_we},      64'd0);
        check("lb_wstrb", {56'd0, cap_wstrb},   64'd0);
        check("lb_rdata", cap_rd,               64'hFFFF_FFFF_FFFF_FF80);
        check("lb_mis",   {63'd0, cap_mis},     64'd0);
        check("lb_hold",  rdata_o,              64'hFFFF_FFFF_FFFF_FF80);

        // LW at 0x5002: misaligned, clears the previous load data
        access(4'b0010, 64'h5002, 64'd0, 64'd0, 0, 0);
        check("lw_mis_lat",   lat,              64'd1);
        check("lw_mis_flag",  {63'd0, cap_mis}, 64'd1);
        check("lw_mis_rdata", cap_rd,           64'd0);
        check("lw_mis_noreq", {63'd0, saw_req}, 64'd0);
        check("lw_mis_hold",  {63'd0, misalign_o}, 64'd1);

        // LHU at 0x2006: top halfword, zero-extended
        access(4'b0101, 64'h2006, 64'd0, 64'hBEEF_0000_0000_0000, 0, 0);
        check("lhu_lat",   lat,              64'd3);
        check("lhu_addr",  cap_addr,         64'h2000);
        check("lhu_rdata", cap_rd,           64'h0000_0000_0000_BEEF);
        check("lhu_mis",   {63'd0, cap_mis}, 64'd0);

        // SW at 0x3004: upper word lanes
        access(4'b1010, 64'h3004, 64'h1122_3344_5566_7788, 64'd0, 0, 0);
        check("sw_lat",   lat,                64'd2);
        check("sw_addr",  cap_addr,           64'h3000);
        check("sw_we",    {63'd0, cap_we},    64'd1);
        check("sw_wstrb", {56'd0, cap_wstrb}, 64'h00F0);
        check("sw_wdata", cap_wdata,          64'h5566_7788_0000_0000);
        check("sw_rdata", cap_rd,             64'd0);

        // SD at 0x4000 with the grant withheld for 4 cycles
        access(4'b1011, 64'h4000, 64'hCAFE_F00D_0123_4567, 64'd0, 4, 0);
        check("sd_lat",      lat,                 64'd6);
        check("sd_req_cyc",  req_cycles,          64'd5);
        check("sd_stable",   {63'd0, unstable},   64'd0);
        check("sd_addr",     cap_addr,            64'h4000);
        check("sd_wstrb",    {56'd0, cap_wstrb},  64'h00FF);
        check("sd_wdata",    cap_wdata,           64'hCAFE_F00D_0123_4567);

        // SD at 0x5004: misaligned doubleword
        access(4'b1011, 64'h5004, 64'h1, 64'd0, 0, 0);
        check("sd_mis_lat",   lat,              64'd1);
        check("sd_mis_flag",  {63'd0, cap_mis}, 64'd1);
        check("sd_mis_rdata", cap_rd,           64'd0);
        check("sd_mis_noreq", {63'd0, saw_req}, 64'd0);

        // LH at 0x0002 with two idle WAIT cycles: sign-extended 0x8001
        access(4'b0001, 64'h0002, 64'd0, 64'h0000_0000_8001_0000, 0, 2);
        check("lh_lat",   lat,    64'd5);
        check("lh_rdata", cap_rd, 64'hFFFF_FFFF_FFFF_8001);

        // LWU at 0x9004, grant withheld 2 cycles while junk rvalid is offered
        access(4'b0110, 64'h9004, 64'd0, 64'hFFFF_FFFF_0000_0000, 2, 0);
        check("lwu_lat",   lat,    64'd5);
        check("lwu_rdata", cap_rd, 64'h0000_0000_FFFF_FFFF);

        // LD with the unsigned bit set behaves as a plain LD
        access(4'b0111, 64'h0008, 64'd0, 64'hF000_0000_0000_0001, 0, 0);
        check("ld_lat",   lat,    64'd3);
        check("ld_addr",  cap_addr, 64'h0008);
        check("ld_rdata", cap_rd, 64'hF000_0000_0000_0001);

        // SB with the unsigned bit set behaves as a plain SB, top lane
        access(4'b1100, 64'h0007, 64'h0000_0000_0000_00AB, 64'd0, 0, 0);
        check("sb_lat",   lat,                64'd2);
        check("sb_wstrb", {56'd0, cap_wstrb}, 64'h0080);
        check("sb_wdata", cap_wdata,          64'hAB00_0000_0000_0000);

        // Reset while in REQ drops mem_req on that edge
        check("rreq_ready", {63'd0, req_ready_o}, 64'd1);
        req_valid_i = 1'b1; lsu_ctrl_i = 4'b1011; addr_i = 64'h7000; wdata_i = 64'h55;
        cyc();
        req_valid_i = 1'b0; lsu_ctrl_i = '0; addr_i = '0; wdata_i = '0;
        check("rreq_req_on", {63'd0, mem_req_o}, 64'd1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("rreq_req_off", {63'd0, mem_req_o},   64'd0);
        check("rreq_ready2",  {63'd0, req_ready_o}, 64'd1);
        cyc();

        // Reset while in WAIT, then a stale rvalid: no response, reset outputs
        req_valid_i = 1'b1; lsu_ctrl_i = 4'b0010; addr_i = 64'h6000;
        cyc();
        req_valid_i = 1'b0; lsu_ctrl_i = '0; addr_i = '0;
        mem_gnt_i = 1'b1;
        cyc();
        mem_gnt_i = 1'b0;
        check("rwait_in_wait", {62'd0, mem_req_o, req_ready_o}, 64'd0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'h1234_5678_9ABC_DEF0;
        if (resp_valid_o) saw_resp = 1'b1;
        cyc();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        for (int i = 0; i < 3; i++) begin
            if (resp_valid_o) saw_resp = 1'b1;
            cyc();
        end
        check("rwait_no_resp", {63'd0, saw_resp},     64'd0);
        check("rwait_ready",   {63'd0, req_ready_o},  64'd1);
        check("rwait_rdata",   rdata_o,               64'd0);
        check("rwait_mis",     {63'd0, misalign_o},   64'd0);
        check("rwait_mem_req", {63'd0, mem_req_o},    64'd0);
        check("rwait_mem_we",  {63'd0, mem_we_o},     64'd0);
        check("rwait_addr",    mem_addr_o,            64'd0);
        check("rwait_wdata",   mem_wdata_o,           64'd0);
        check("rwait_wstrb",   {56'd0, mem_wstrb_o},  64'd0);

        // Recovery: an ordinary load works after the abandoned access
        access(4'b0100, 64'h0001, 64'd0, 64'h0000_0000_0000_9900, 0, 0);
        check("post_lat",   lat,    64'd3);
        check("post_rdata", cap_rd, 64'h0000_0000_0000_0099);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/core_lsu.md
# core_lsu

Load/store unit for the RV64IM core's memory stage. Takes the effective address produced by the execute-stage ALU together with the store data and the memory-access control, and runs one aligned access on a 64-bit data-memory port through a request/grant/response handshake. It returns sign- or zero-extended load data to writeback and flags misaligned accesses without touching memory. Exactly one access is in flight at a time.

## Interface
Parameters:
- `XLEN`, 64: data and address width (equals `OPERAND_WIDTH`).

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `req_valid_i`  in  1  access request from the execute stage.
- `req_ready_o`  out  1  LSU idle and able to accept a request.
- `lsu_ctrl_i`  in  `LSU_CTRL_WIDTH` (4)  bit 3 = store; bit 2 = unsigned load; bits 1:0 = size (00 B, 01 H, 10 W, 11 D).
- `addr_i`  in  XLEN  effective byte address (ALU output).
- `wdata_i`  in  XLEN  store data (rs2), right-aligned.
- `resp_valid_o`  out  1  one-cycle completion pulse.
- `rdata_o`  out  XLEN  extended load data; 0 for stores and misaligned accesses.
- `misalign_o`  out  1  valid with `resp_valid_o`; access was not naturally aligned.
- `mem_req_o`  out  1  memory request.
- `mem_we_o`  out  1  1 = write.
- `mem_addr_o`  out  XLEN  doubleword-aligned address (`addr[2:0]` forced to 0).
- `mem_wdata_o`  out  XLEN  lane-shifted store data.
- `mem_wstrb_o`  out  8  byte enables; 0 for reads.
- `mem_gnt_i`  in  1  memory accepted the request this cycle.
- `mem_rvalid_i`  in  1  read data valid.
- `mem_rdata_i`  in  XLEN  read doubleword.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: `req_ready_o`=1. On `req_valid_i`, register ctrl, address, and store data. If the access is misaligned, go to RESP with `misalign_o` set. Otherwise go to REQ.
- Misaligned when any of these holds: H with `addr[0]`≠0; W with `addr[1:0]`≠0; D with `addr[2:0]`≠0. B is never misaligned.
- REQ: `mem_req_o`=1 and address, write-enable, data, and strobe are held stable until `mem_gnt_i`.
  - On grant, a store goes to RESP and a load goes to WAIT.
  - `mem_rvalid_i` is ignored in REQ.
- WAIT: on `mem_rvalid_i`, capture the extended data into `rdata_o` and go to RESP. The LSU waits indefinitely.
- RESP: `resp_valid_o`=1 for exactly one cycle, then IDLE. `req_ready_o`=0, so back-to-back accesses are at least one IDLE cycle apart.
- Store lanes:
  - Let `off` = `addr[2:0]`.
  - `mem_wdata_o` = `wdata_i` << (8·off).
  - `mem_wstrb_o` = mask << off, where mask is 0x01 (B), 0x03 (H), 0x0F (W), or 0xFF (D).
- Load extraction:
  - Shift `mem_rdata_i` right by 8·off and keep 8, 16, 32, or 64 bits.
  - Sign-extend unless bit 2 is set; D ignores bit 2.
- Store with bit 2 set is treated as a plain store.
- `rdata_o` and `misalign_o` hold their values until the next RESP. Both are cleared on entry to REQ or to a misaligned RESP.

## Timing
- Reset values: state IDLE; `req_ready_o`=1; `resp_valid_o`, `misalign_o`, `mem_req_o`, `mem_we_o`=0; `rdata_o`, `mem_addr_o`, `mem_wdata_o`, `mem_wstrb_o`=0.
- Latency from the accept edge to `resp_valid_o`, with zero-wait memory:
  - store: 2 cycles (REQ, RESP);
  - load: 3 cycles (REQ, WAIT with rvalid, RESP);
  - misaligned: 1 cycle.
- Each cycle without grant adds one REQ cycle. Each cycle without rvalid adds one WAIT cycle.
- All outputs are registered or decoded from state only; there is no combinational path from `mem_*_i` to `mem_req_o` or to `resp_valid_o`.
- Reset mid-access (sampled low at any edge) returns to IDLE and deasserts `mem_req_o` on that edge. A late `mem_rvalid_i` arriving after reset is ignored. No response is produced for the abandoned access.
- `req_valid_i` outside IDLE is ignored. The execute stage must hold the request until it sees ready.

## Structure
- Add `LSU_CTRL_WIDTH` (4) and the size codes `LSU_B`/`LSU_H`/`LSU_W`/`LSU_D` to `defines.v`. Bit positions `LSU_STORE_BIT`=3 and `LSU_UNS_BIT`=2 are also constants there.
- One natural sub-module, `core_lsu_align`: a combinational block producing the store-lane shift, the strobe, the misalign flag, and load extraction/extension. The FSM and registers stay in `core_lsu`.

## Test plan
- LB, address 0x1003, memory doubleword 0x0000_0000_8000_0000, zero-wait → `mem_addr_o`=0x1000, `rdata_o`=0xFFFF_FFFF_FFFF_FF80, `resp_valid_o` 3 cycles after accept.
- LHU, address 0x2006, doubleword 0xBEEF_0000_0000_0000 → `rdata_o`=0x0000_0000_0000_BEEF, `misalign_o`=0.
- SW, address 0x3004, `wdata_i`=0x1122_3344_5566_7788 → `mem_wstrb_o`=0xF0, `mem_wdata_o`=0x5566_7788_0000_0000, `mem_we_o`=1, response 2 cycles after accept.
- SD, address 0x4000, with `mem_gnt_i` held low for 4 cycles → `mem_req_o`, address, and data stay stable all 5 REQ cycles, and response follows the grant by one cycle.
- LW at 0x5002 and SD at 0x5004 → `misalign_o`=1, `rdata_o`=0, `mem_req_o` never asserted, response 1 cycle after accept.
- Load in WAIT, `rst_n` low for one cycle, then a stale `mem_rvalid_i` → IDLE, no `resp_valid_o`, all outputs at reset values, `req_ready_o`=1.
